// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared defaults and address type for the register file with write-pending scoreboard
package reg_file_sb_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);
    typedef logic [AW_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: busy vector, busy counter and RAW/WAW hazard; same-cycle writeback forwarding under REGFILE_BYPASS_EN
module reg_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs1_addr,
    input  logic          rs1_use,
    input  logic [AW-1:0] rs2_addr,
    input  logic          rs2_use,
    input  logic          rsv_en,
    input  logic [AW-1:0] rsv_addr,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    output logic          hazard,
    output logic [AW:0]   busy_cnt
);
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            pend1, pend2, pendw, rsv_ok, wb_clr, inc, dec;
`ifdef REGFILE_BYPASS_EN
    // a writeback landing this cycle already resolves its register
    assign pend1 = busy_q[rs1_addr] & ~(wb_en & (wb_addr == rs1_addr));
    assign pend2 = busy_q[rs2_addr] & ~(wb_en & (wb_addr == rs2_addr));
    assign pendw = busy_q[rsv_addr] & ~(wb_en & (wb_addr == rsv_addr));
`else
    assign pend1 = busy_q[rs1_addr];
    assign pend2 = busy_q[rs2_addr];
    assign pendw = busy_q[rsv_addr];
`endif
    assign hazard   = (rs1_use & pend1) | (rs2_use & pend2) | (rsv_en & pendw);
    assign rsv_ok   = rsv_en & ~hazard & (rsv_addr != '0);
    assign wb_clr   = wb_en & (wb_addr != '0);
    assign inc      = rsv_ok & ~busy_q[rsv_addr];
    assign dec      = wb_clr & busy_q[wb_addr] & ~(rsv_ok & (rsv_addr == wb_addr));
    assign cnt_d    = cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
    assign busy_cnt = cnt_q;
    // clear on writeback first so a same-register reservation wins (new producer)
    always_comb begin
        busy_d = busy_q;
        if (wb_clr) busy_d[wb_addr] = 1'b0;
        if (rsv_ok) busy_d[rsv_addr] = 1'b1;
    end
    // busy vector and its population counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: NREG x XLEN register file, two combinational reads, one write, write-pending scoreboard; REGFILE_BYPASS_EN enables writeback-to-read forwarding
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic            rs1_use,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            rs2_use,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            hazard,
    output logic [AW:0]     busy_cnt
);
    logic [XLEN-1:0] mem_q [NREG];
    logic            fwd1, fwd2;
`ifdef REGFILE_BYPASS_EN
    assign fwd1 = wb_en & (wb_addr == rs1_addr);
    assign fwd2 = wb_en & (wb_addr == rs2_addr);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif
    // x0 is hard-wired to zero regardless of array contents or forwarding
    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : fwd1 ? wb_data : mem_q[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : fwd2 ? wb_data : mem_q[rs2_addr];
    end
    // data array; writes to x0 are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            mem_q[wb_addr] <= wb_data;
        end
    end
    reg_scoreboard #(.NREG(NREG)) u_sb (
        .clk     (clk),
        .rst     (rst),
        .rs1_addr(rs1_addr),
        .rs1_use (rs1_use),
        .rs2_addr(rs2_addr),
        .rs2_use (rs2_use),
        .rsv_en  (rsv_en),
        .rsv_addr(rsv_addr),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .hazard  (hazard),
        .busy_cnt(busy_cnt)
    );
endmodule
